// File: rtl/shared_dmem_pkg.sv
// Shared data-memory arbiter: FSM state encoding
// and width helpers used by the arbiter slice.
package shared_dmem_pkg;

  localparam logic [1:0] S_ARB   = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef enum logic [1:0] {
    ARB   = S_ARB,
    ISSUE = S_ISSUE,
    WAIT  = S_WAIT,
    RESP  = S_RESP
  } state_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted
// request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] j;

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        win[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/shared_dmem_arbiter.sv
// N-core round-robin arbiter in front of one
// single-ported DRAM, plus sticky all_done.
import shared_dmem_pkg::*;

module shared_dmem_arbiter #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CORES-1:0]          req,
  input  logic [N_CORES-1:0]          we,
  input  logic [N_CORES*ADDR_W-1:0]   addr,
  input  logic [N_CORES*DATA_W-1:0]   wdata,
  output logic [N_CORES-1:0]          gnt,
  output logic [N_CORES-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic [N_CORES-1:0]          core_done,
  output logic                        busy,
  output logic                        all_done
);

  localparam int PW = ptr_w(N_CORES);
  localparam int CW = cnt_w(MEM_LAT);

  state_t state, state_nx;

  logic [PW-1:0]      ptr;
  logic [N_CORES-1:0] w_hot;
  logic               cap_we;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_wdata;
  logic [CW-1:0]      cnt;

  logic [N_CORES-1:0] win;
  logic [PW-1:0]      win_idx;
  logic               any;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  rr_arbiter #(
    .N  (N_CORES),
    .PW (PW)
  ) u_rr (
    .req (req),
    .ptr (ptr),
    .win (win),
    .idx (win_idx),
    .any (any)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (win[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    gnt       = '0;
    rvalid    = '0;
    mem_we    = 1'b0;
    mem_addr  = cap_addr;
    mem_wdata = cap_wdata;
    busy      = (state != ARB);
    unique case (state)
      ARB: begin
        if (any) state_nx = ISSUE;
      end
      ISSUE: begin
        gnt      = w_hot;
        mem_we   = cap_we;
        state_nx = cap_we ? ARB : WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nx = RESP;
      end
      RESP: begin
        rvalid   = w_hot;
        state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      ptr       <= '0;
      w_hot     <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cnt       <= '0;
      rdata     <= '0;
      all_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      all_done <= all_done | (&core_done);
      if (state == ARB && any) begin
        w_hot     <= win;
        cap_we    <= sel_we;
        cap_addr  <= sel_addr;
        cap_wdata <= sel_wdata;
        ptr       <= (win_idx == PW'(N_CORES - 1))
                     ? '0 : win_idx + 1'b1;
      end
      if (state == ISSUE) begin
        cnt <= CW'(MEM_LAT - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // capture on the last WAIT cycle so rvalid
      // and the new rdata appear together in RESP
      if (state == WAIT && cnt == '0) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Bench for shared_dmem_arbiter: vector table,
// grant/response scoreboard, corner sequences.
module tb_shared_dmem_arbiter;

  typedef struct {
    int          core;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int   core;
    logic we;
  } gq_t;

  typedef struct {
    int          core;
    logic [15:0] d;
  } rq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  core_done = '0;

  logic [3:0]  req_a = '0, we_a = '0;
  logic [63:0] addr_a = '0, wdata_a = '0;
  logic [3:0]  gnt_a, rvalid_a;
  logic [15:0] rdata_a, mem_addr_a;
  logic [15:0] mem_wdata_a, mem_rdata_a;
  logic        mem_we_a, busy_a, all_done_a;

  logic [3:0]  req_b = '0, we_b = '0;
  logic [63:0] addr_b = '0, wdata_b = '0;
  logic [3:0]  gnt_b, rvalid_b;
  logic [15:0] rdata_b, mem_addr_b;
  logic [15:0] mem_wdata_b, mem_rdata_b;
  logic        mem_we_b, busy_b, all_done_b;

  always #5 clk = ~clk;

  shared_dmem_arbiter #(
    .N_CORES(4), .DATA_W(16), .ADDR_W(16), .MEM_LAT(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .gnt(gnt_a),
    .rvalid(rvalid_a), .rdata(rdata_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a),
    .core_done(core_done), .busy(busy_a),
    .all_done(all_done_a)
  );

  shared_dmem_arbiter #(
    .N_CORES(4), .DATA_W(16), .ADDR_W(16), .MEM_LAT(3)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .gnt(gnt_b),
    .rvalid(rvalid_b), .rdata(rdata_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b),
    .core_done(core_done), .busy(busy_b),
    .all_done(all_done_b)
  );

  // DRAM models; unwritten words read as {A5, addr[7:0]}
  bit [15:0] mem_a [256];
  bit        wr_a  [256];
  bit [7:0]  pipe_a;
  bit [15:0] mem_b [256];
  bit        wr_b  [256];
  bit [7:0]  pipe_b [3];

  always @(posedge clk) begin
    if (mem_we_a) begin
      mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
      wr_a[mem_addr_a[7:0]]  <= 1'b1;
    end
    pipe_a <= mem_addr_a[7:0];
    if (mem_we_b) begin
      mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
      wr_b[mem_addr_b[7:0]]  <= 1'b1;
    end
    pipe_b[0] <= mem_addr_b[7:0];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign mem_rdata_a = wr_a[pipe_a] ? mem_a[pipe_a]
                     : {8'hA5, pipe_a};
  assign mem_rdata_b = wr_b[pipe_b[2]] ? mem_b[pipe_b[2]]
                     : {8'hA5, pipe_b[2]};

  int  n_tests = 0;
  int  n_fail  = 0;
  gq_t gnt_q[$];
  rq_t rsp_q[$];
  int  reps[4];
  bit  waiting[4];
  bit  outst;

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endfunction

  function automatic logic [3:0] hot(input int i);
    logic [3:0] h;
    h = '0;
    h[i] = 1'b1;
    return h;
  endfunction

  task automatic step();
    gq_t g;
    rq_t r;
    @(posedge clk);
    #1;
    if (gnt_a != '0) begin
      chk("gnt_onehot", 32'($onehot(gnt_a)), 1);
      chk("gnt_while_outstanding", 32'(outst), 0);
      if (gnt_q.size() == 0) begin
        chk("gnt_unexpected", 32'(gnt_a), 0);
      end else begin
        g = gnt_q.pop_front();
        chk("gnt_core", 32'(gnt_a), 32'(hot(g.core)));
        outst = !g.we;
      end
    end
    if (rvalid_a != '0) begin
      if (rsp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'(rvalid_a), 0);
      end else begin
        r = rsp_q.pop_front();
        chk("rvalid_core", 32'(rvalid_a),
            32'(hot(r.core)));
        chk("rdata", 32'(rdata_a), 32'(r.d));
      end
      outst = 1'b0;
    end
    if (mem_we_a) chk("mem_we_only_issue", 32'(|gnt_a), 1);
    for (int i = 0; i < 4; i++) begin
      if (gnt_a[i]) begin
        req_a[i] = 1'b0;
        if (!we_a[i]) waiting[i] = 1'b1;
      end
      if (rvalid_a[i]) waiting[i] = 1'b0;
      if (!req_a[i] && !waiting[i] && reps[i] > 0) begin
        reps[i]--;
        req_a[i] = 1'b1;
        we_a[i]  = 1'b0;
        addr_a[i*16 +: 16] = 16'h0040 + 16'(i);
      end
    end
  endtask

  task automatic clear_bench();
    req_a = '0;
    we_a  = '0;
    req_b = '0;
    outst = 1'b0;
    gnt_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 4; i++) begin
      reps[i]    = 0;
      waiting[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_bench();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic drain(input int budget,
                       input string name);
    int t;
    t = 0;
    while ((gnt_q.size() != 0 || rsp_q.size() != 0 ||
            busy_a || req_a != '0) && t < budget) begin
      step();
      t++;
    end
    chk(name, 32'(gnt_q.size() + rsp_q.size()), 0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int          g_at, r_at, b_at, wes;
    logic [15:0] rd;
    g_at = -1;
    r_at = -1;
    b_at = -1;
    wes  = 0;
    rd   = '0;
    gnt_q.push_back('{v.core, v.we});
    if (!v.we) rsp_q.push_back('{v.core, v.exp_rd});
    req_a[v.core] = 1'b1;
    we_a[v.core]  = v.we;
    addr_a[v.core*16 +: 16]  = v.addr;
    wdata_a[v.core*16 +: 16] = v.wdata;
    for (int t = 1; t <= 12; t++) begin
      step();
      if (gnt_a[v.core] && g_at < 0) g_at = t;
      if (mem_we_a) wes++;
      if (rvalid_a[v.core] && r_at < 0) begin
        r_at = t;
        rd   = rdata_a;
      end
      if (g_at > 0 && !busy_a && b_at < 0) b_at = t;
    end
    chk($sformatf("vec%0d_gnt_lat", n), 32'(g_at), 1);
    if (v.we) begin
      chk($sformatf("vec%0d_we_cycles", n), 32'(wes), 1);
      chk($sformatf("vec%0d_idle_lat", n), 32'(b_at),
          32'(v.exp_lat));
    end else begin
      chk($sformatf("vec%0d_we_cycles", n), 32'(wes), 0);
      chk($sformatf("vec%0d_rsp_lat", n), 32'(r_at),
          32'(v.exp_lat));
      chk($sformatf("vec%0d_rd", n), 32'(rd),
          32'(v.exp_rd));
    end
  endtask

  initial begin
    vec_t        tbl[8];
    int          gb, bb, rb, seen;
    logic [15:0] rd;

    tbl[0] = '{1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 2};
    tbl[1] = '{2, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3};
    tbl[2] = '{0, 1'b0, 16'h0020, 16'h0000, 16'hA520, 3};
    tbl[3] = '{3, 1'b1, 16'h0020, 16'h1234, 16'h0000, 2};
    tbl[4] = '{3, 1'b0, 16'h0020, 16'h0000, 16'h1234, 3};
    tbl[5] = '{0, 1'b1, 16'h00FF, 16'h0000, 16'h0000, 2};
    tbl[6] = '{1, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 3};
    tbl[7] = '{2, 1'b0, 16'h0011, 16'h0000, 16'hA511, 3};

    clear_bench();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt_a), 0);
    chk("rst_rvalid", 32'(rvalid_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_mem_we", 32'(mem_we_a), 0);
    chk("rst_all_done", 32'(all_done_a), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    // MEM_LAT=3 instance: write then read back
    req_b[1] = 1'b1;
    we_b[1]  = 1'b1;
    addr_b[31:16]  = 16'h0010;
    wdata_b[31:16] = 16'hBEEF;
    gb = -1;
    bb = -1;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk);
      #1;
      if (gnt_b[1] && gb < 0) begin
        gb = t;
        req_b[1] = 1'b0;
      end
      if (gb > 0 && !busy_b && bb < 0) bb = t;
    end
    chk("lat3_wr_gnt_lat", 32'(gb), 1);
    chk("lat3_wr_idle_lat", 32'(bb), 2);
    req_b[2] = 1'b1;
    we_b[2]  = 1'b0;
    addr_b[47:32] = 16'h0010;
    gb = -1;
    rb = -1;
    rd = '0;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk);
      #1;
      if (gnt_b[2] && gb < 0) begin
        gb = t;
        req_b[2] = 1'b0;
      end
      if (rvalid_b != '0 && rb < 0) begin
        rb = t;
        rd = rdata_b;
        chk("lat3_rvalid_core", 32'(rvalid_b), 32'h4);
      end
    end
    chk("lat3_rd_gnt_lat", 32'(gb), 1);
    chk("lat3_rsp_lat", 32'(rb), 5);
    chk("lat3_rdata", 32'(rd), 32'hBEEF);

    // all four cores reading continuously
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        gnt_q.push_back('{i, 1'b0});
        rsp_q.push_back('{i, 16'hA540 + 16'(i)});
      end
    end
    for (int i = 0; i < 4; i++) reps[i] = 2;
    drain(100, "allreq_drain");

    // ptr=2 after a core1 access, then req=1011
    run_vec(8, '{1, 1'b1, 16'h0030, 16'h5555, 16'h0, 2});
    gnt_q.push_back('{3, 1'b0});
    gnt_q.push_back('{0, 1'b0});
    gnt_q.push_back('{1, 1'b0});
    rsp_q.push_back('{3, 16'hA543});
    rsp_q.push_back('{0, 16'hA540});
    rsp_q.push_back('{1, 16'hA541});
    reps[0] = 1;
    reps[1] = 1;
    reps[3] = 1;
    drain(60, "ptr2_drain");

    // staggered core_done
    core_done[0] = 1'b1;
    step();
    chk("done_after_bit0", 32'(all_done_a), 0);
    core_done[2] = 1'b1;
    step();
    chk("done_after_bit2", 32'(all_done_a), 0);
    core_done[1] = 1'b1;
    step();
    chk("done_after_bit1", 32'(all_done_a), 0);
    core_done[3] = 1'b1;
    #1;
    chk("done_not_comb", 32'(all_done_a), 0);
    step();
    chk("done_set", 32'(all_done_a), 1);
    core_done[0] = 1'b0;
    step();
    step();
    step();
    chk("done_sticky", 32'(all_done_a), 1);

    // reset asserted while a read sits in WAIT
    gnt_q.push_back('{2, 1'b0});
    reps[2] = 1;
    seen = 0;
    for (int t = 0; t < 10 && seen == 0; t++) begin
      step();
      if (gnt_a[2]) seen = 1;
    end
    chk("wrst_gnt_seen", 32'(seen), 1);
    step();
    chk("wrst_in_wait", 32'(busy_a && gnt_a == '0 &&
                           rvalid_a == '0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("wrst_gnt", 32'(gnt_a), 0);
    chk("wrst_rvalid", 32'(rvalid_a), 0);
    chk("wrst_rdata", 32'(rdata_a), 0);
    chk("wrst_mem_we", 32'(mem_we_a), 0);
    chk("wrst_mem_addr", 32'(mem_addr_a), 0);
    chk("wrst_mem_wdata", 32'(mem_wdata_a), 0);
    chk("wrst_busy", 32'(busy_a), 0);
    chk("wrst_all_done", 32'(all_done_a), 0);
    clear_bench();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    gnt_q.push_back('{0, 1'b0});
    gnt_q.push_back('{3, 1'b0});
    rsp_q.push_back('{0, 16'hA540});
    rsp_q.push_back('{3, 16'hA543});
    reps[0] = 1;
    reps[3] = 1;
    seen = 0;
    for (int t = 0; t < 40 && (gnt_q.size() != 0 ||
         rsp_q.size() != 0 || busy_a); t++) begin
      step();
      if (rvalid_a[2]) seen = 1;
    end
    chk("wrst_no_stale_rvalid", 32'(seen), 0);
    chk("wrst_drain", 32'(gnt_q.size() + rsp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
